// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands added CHUNK bits per clock
// through a single ripple stage, with start/done handshake and carry/overflow flags.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last;
    int               base;
    logic [CHUNK:0]   chunk_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                in_ready  = 1'b1;
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = start && in_ready;
    end

    assign last = (idx == LAST_IDX);
    assign base = int'(idx) * CHUNK;

    // One ripple stage, reused for every chunk; carry_r links consecutive cycles.
    assign chunk_res = {1'b0, a_r[base +: CHUNK]} + {1'b0, b_r[base +: CHUNK]}
                     + {{CHUNK{1'b0}}, carry_r};

    // Operand holding registers are only read in RUN, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= sub ? ~b : b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            carry_r <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            carry_r <= sub | cin;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (state == RUN) begin
            sum[base +: CHUNK] <= chunk_res[CHUNK-1:0];
            carry_r            <= chunk_res[CHUNK];
            if (last) begin
                // chunk_res[CHUNK-1] is the result sign bit being written this edge.
                cout <= chunk_res[CHUNK];
                ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (chunk_res[CHUNK-1] != a_r[WIDTH-1]);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule
